apb4_slave_mem: RTL and testbench
=================================

Name: apb4_slave_mem

Overview:
APB4 completer fronting a byte-strobed word memory; the next generation of the team's basic APB slave.
Adds configurable wait states, PSTRB byte-lane writes, and PSLVERR on out-of-range or misaligned addresses.
Adds clean abort handling on protocol violation.
Sits behind the APB bridge/decoder as a generic scratch/config memory target.

Parameters:
ADDR_WIDTH, 8, PADDR width; byte address.
DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8, at most 64.
MEM_DEPTH, 64, number of DATA_WIDTH words; at most 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
WAIT_STATES, 0, extra PREADY-low cycles inserted in every access phase; range 0..15.

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  slave select
PENABLE  in  1  access-phase indicator
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  DATA_WIDTH/8  write byte enables; ignored on reads
PRDATA  out  DATA_WIDTH  read data
PREADY  out  1  transfer completion, registered
PSLVERR  out  1  error response, valid only while PREADY=1

Behaviour:
- Reset: PREADY=0, PSLVERR=0, PRDATA=0, state=IDLE, wait counter=0. Memory contents are not reset and are undefined until written.
- Word index = PADDR >> log2(DATA_WIDTH/8).
- Error condition: word index >= MEM_DEPTH, or PADDR low log2(DATA_WIDTH/8) bits nonzero.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: PREADY=0. PSEL=1 and PENABLE=0 (setup phase) -> ACCESS, counter loaded with WAIT_STATES. PSEL=1 with PENABLE=1 while in IDLE is ignored and stays IDLE.
  - ACCESS, counter != 0: decrement counter, PREADY stays 0.
  - ACCESS, counter == 0: at this edge, register PREADY=1 and PSLVERR=error, and perform the access -> RESP.
    - Read: PRDATA <= memory[index], or 0 if error.
    - Write: for each lane i with PSTRB[i]=1, memory byte i <= PWDATA byte i. No write if error.
  - ACCESS, PSEL=0 or PENABLE=0 (abort / protocol violation): -> IDLE, no memory update, PREADY=0, PSLVERR=0.
  - RESP: PREADY=1 this cycle and the master completes. Next edge: PREADY<=0, PSLVERR<=0, PRDATA<=0, -> IDLE.
- Latency: access phase lasts WAIT_STATES+2 cycles with PREADY high in the last one. Each transfer takes WAIT_STATES+3 cycles including setup.
- Back-to-back: a setup phase in the cycle after RESP is accepted from IDLE with no bubble beyond the IDLE cycle it occupies.
- Inputs PADDR/PWRITE/PWDATA/PSTRB are sampled at the ACCESS-exit edge. APB guarantees they are stable from setup.
- PSTRB=0 on a write: legal, memory unchanged, PSLVERR=0.
- Read and write never occur in the same cycle; no forwarding is needed.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. A write not yet committed is lost; a committed write is retained.
- State encoding: any illegal state value -> IDLE.

Test Plan:
1. WAIT_STATES=2: write 0xDEADBEEF to PADDR 0x10, PSTRB=0xF, then read 0x10 -> PREADY low for 3 access cycles then high for 1; PRDATA=0xDEADBEEF, PSLVERR=0.
2. Byte strobes: write 0xFFFFFFFF to 0x20, then write 0x00000000 with PSTRB=0x5, then read 0x20 -> PRDATA=0xFF00FF00.
3. Out of range: write to PADDR 0x100>>... i.e. word 64 (PADDR 0x100 with ADDR_WIDTH=10), and read PADDR 0x04 misaligned as 0x05 -> PSLVERR=1 with PREADY; PRDATA=0; memory word 1 unchanged on a subsequent aligned read.
4. Abort: drop PSEL during the second wait cycle of a write to 0x30 -> FSM returns to IDLE, PREADY never asserts; later read of 0x30 returns the prior value.
5. Reset mid-access: assert PRESETn=0 during ACCESS -> PREADY/PSLVERR/PRDATA go 0 asynchronously; the next transfer completes normally.
6. WAIT_STATES=0 back-to-back: 4 consecutive writes then 4 reads to 0x00..0x0C -> each transfer takes 3 cycles and the data read back matches.

Source files
------------

// File: rtl/apb4_slave_mem.sv
// rtl/apb4_slave_mem.sv - APB4 completer fronting a byte-strobed word memory
module apb4_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CMP_W  = ADDR_WIDTH + 1;

    // One spare bit so MEM_DEPTH == 2^(word index width) still compares correctly
    localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(MEM_DEPTH);
    localparam logic [3:0]       WAIT_LD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    access_err;

    // Address decode: byte address to word index, plus the two error sources
    assign word_idx     = PADDR >> OFF_W;
    assign mem_idx      = word_idx[IDX_W-1:0];
    assign out_of_range = {1'b0, word_idx} >= DEPTH_C;
    assign access_err   = misaligned | out_of_range;

    generate
        if (OFF_W == 0) begin : g_no_offset
            assign misaligned = 1'b0;
        end else begin : g_offset
            assign misaligned = |PADDR[OFF_W-1:0];
        end
    endgenerate

    // Next-state and registered-output logic; outputs default to idle values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Only a proper setup phase starts a transfer; a stray
                // PSEL+PENABLE without setup is ignored
                if (PSEL && !PENABLE) begin
                    state_d = S_ACCESS;
                    cnt_d   = WAIT_LD;
                end
            end
            S_ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    // Master abandoned the transfer: drop it without side effects
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = access_err;
                    if (!access_err) begin
                        if (PWRITE) begin
                            mem_we = 1'b1;
                        end else begin
                            prdata_d = mem_q[mem_idx];
                        end
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control and response registers, cleared asynchronously
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Byte-lane memory write; storage itself is never reset
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (PSTRB[i]) begin
                    mem_q[mem_idx][i*8 +: 8] <= PWDATA[i*8 +: 8];
                end
            end
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb4_slave_mem.sv
// tb/tb_apb4_slave_mem.sv - self-checking bench for apb4_slave_mem
module tb_apb4_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dsel;
    logic        psel, penable, pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata, prdata0, prdata1;
    logic        pready, pready0, pready1;
    logic        pslverr, pslverr0, pslverr1;
    logic        psel0, psel1;

    int checks = 0;
    int errors = 0;

    // Reference memory: bytes plus a known flag, per DUT (0: no waits, 1: two waits)
    logic [7:0] mb [2][256];
    bit         mk [2][256];

    always #5 clk = ~clk;

    assign psel0   = psel & ~dsel;
    assign psel1   = psel & dsel;
    assign prdata  = dsel ? prdata1 : prdata0;
    assign pready  = dsel ? pready1 : pready0;
    assign pslverr = dsel ? pslverr1 : pslverr0;

    apb4_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr[7:0]), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb4_slave_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(2)) u_dut1 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
    );

    function automatic bit exp_err(input logic [9:0] a);
        return (a % 4 != 0) || (a / 4 >= 64);
    endfunction

    function automatic int exp_cyc(input bit d);
        return d ? 4 : 2;
    endfunction

    task automatic model_wr(input bit d, input logic [9:0] a, input logic [31:0] wd, input logic [3:0] st);
        if (!exp_err(a)) begin
            for (int i = 0; i < 4; i++) begin
                if (st[i]) begin
                    mb[d][int'(a) + i] = wd[i*8 +: 8];
                    mk[d][int'(a) + i] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_rd(input bit d, input logic [9:0] a, output logic [31:0] ev, output logic [31:0] mask);
        ev   = '0;
        mask = '1;
        if (!exp_err(a)) begin
            for (int i = 0; i < 4; i++) begin
                ev[i*8 +: 8]   = mb[d][int'(a) + i];
                mask[i*8 +: 8] = mk[d][int'(a) + i] ? 8'hFF : 8'h00;
            end
        end
    endtask

    // One APB transfer; returns after sampling PREADY high (bus left in access phase)
    task automatic xfer(input bit d, input bit wr, input logic [9:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic err, output int cyc);
        bit done;
        @(posedge clk); #1;
        dsel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0; done = 1'b0; rd = 'x; err = 1'bx;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (pready) begin
                rd = prdata; err = pslverr; done = 1'b1;
            end
        end
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dsel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            dsel = d[0];
            #1;
            checks++;
            if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: pready=%b pslverr=%b prdata=%h, want 0/0/0", d, pready, pslverr, prdata);
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, ev, mask; logic err; int cyc;
        xfer(1'b1, 1'b1, 10'h10, 32'hDEADBEEF, 4'hF, rd, err, cyc);
        model_wr(1'b1, 10'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if (cyc !== 4 || err !== 1'b0) begin
            errors++;
            $display("FAIL ws_write: cycles=%0d pslverr=%b, want 4/0", cyc, err);
        end
        xfer(1'b1, 1'b0, 10'h10, 32'h0, 4'h0, rd, err, cyc);
        model_rd(1'b1, 10'h10, ev, mask);
        checks++;
        if (cyc !== 4 || err !== 1'b0 || rd !== ev || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ws_read: cycles=%0d pslverr=%b prdata=%h, want 4/0/%h", cyc, err, rd, ev);
        end
        bus_idle();
    endtask

    task automatic test_strobes();
        logic [31:0] rd, ev, mask; logic err; int cyc;
        xfer(1'b1, 1'b1, 10'h20, 32'hFFFFFFFF, 4'hF, rd, err, cyc);
        model_wr(1'b1, 10'h20, 32'hFFFFFFFF, 4'hF);
        xfer(1'b1, 1'b1, 10'h20, 32'h00000000, 4'h5, rd, err, cyc);
        model_wr(1'b1, 10'h20, 32'h00000000, 4'h5);
        xfer(1'b1, 1'b1, 10'h20, 32'h12345678, 4'h0, rd, err, cyc);
        checks++;
        if (err !== 1'b0 || cyc !== 4) begin
            errors++;
            $display("FAIL strb_zero: pslverr=%b cycles=%0d, want 0/4", err, cyc);
        end
        xfer(1'b1, 1'b0, 10'h20, 32'h0, 4'h0, rd, err, cyc);
        model_rd(1'b1, 10'h20, ev, mask);
        checks++;
        if (rd !== 32'hFF00FF00 || rd !== ev || err !== 1'b0) begin
            errors++;
            $display("FAIL strobes: prdata=%h pslverr=%b, want %h/0", rd, err, ev);
        end
        bus_idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int cyc;
        xfer(1'b1, 1'b1, 10'h04, 32'hA5A5_5A5A, 4'hF, rd, err, cyc);
        model_wr(1'b1, 10'h04, 32'hA5A5_5A5A, 4'hF);
        xfer(1'b1, 1'b1, 10'h100, 32'h1111_1111, 4'hF, rd, err, cyc);
        checks++;
        if (err !== 1'b1 || cyc !== 4) begin
            errors++;
            $display("FAIL range_write: pslverr=%b cycles=%0d, want 1/4", err, cyc);
        end
        xfer(1'b1, 1'b1, 10'h05, 32'h2222_2222, 4'hF, rd, err, cyc);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_write: pslverr=%b, want 1", err);
        end
        xfer(1'b1, 1'b0, 10'h05, 32'h0, 4'h0, rd, err, cyc);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL misalign_read: pslverr=%b prdata=%h, want 1/00000000", err, rd);
        end
        xfer(1'b1, 1'b0, 10'h104, 32'h0, 4'h0, rd, err, cyc);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL range_read: pslverr=%b prdata=%h, want 1/00000000", err, rd);
        end
        xfer(1'b1, 1'b0, 10'h04, 32'h0, 4'h0, rd, err, cyc);
        checks++;
        if (err !== 1'b0 || rd !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL word1_intact: pslverr=%b prdata=%h, want 0/a5a55a5a", err, rd);
        end
        bus_idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd, ev, mask; logic err; int cyc; int seen;
        xfer(1'b1, 1'b1, 10'h30, 32'h1234_5678, 4'hF, rd, err, cyc);
        model_wr(1'b1, 10'h30, 32'h1234_5678, 4'hF);
        bus_idle();
        @(posedge clk); #1;
        dsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h30; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (pready1 === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_pready: high for %0d cycles, want 0", seen);
        end
        xfer(1'b1, 1'b0, 10'h30, 32'h0, 4'h0, rd, err, cyc);
        model_rd(1'b1, 10'h30, ev, mask);
        checks++;
        if (rd !== ev || err !== 1'b0 || cyc !== 4) begin
            errors++;
            $display("FAIL abort_data: prdata=%h pslverr=%b cycles=%0d, want %h/0/4", rd, err, cyc, ev);
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, ev, mask; logic err; int cyc;
        xfer(1'b1, 1'b0, 10'h10, 32'h0, 4'h0, rd, err, cyc);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd !== 32'hDEADBEEF || pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp: before=%h after pready=%b pslverr=%b prdata=%h, want deadbeef 0/0/0", rd, pready, pslverr, prdata);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b1, 1'b1, 10'h44, 32'h0BAD_C0DE, 4'hF, rd, err, cyc);
        model_wr(1'b1, 10'h44, 32'h0BAD_C0DE, 4'hF);
        bus_idle();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h44; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_access: pready=%b pslverr=%b prdata=%h, want 0/0/0", pready, pslverr, prdata);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b1, 1'b0, 10'h44, 32'h0, 4'h0, rd, err, cyc);
        model_rd(1'b1, 10'h44, ev, mask);
        checks++;
        if (rd !== ev || err !== 1'b0 || cyc !== 4) begin
            errors++;
            $display("FAIL reset_recover: prdata=%h pslverr=%b cycles=%0d, want %h/0/4", rd, err, cyc, ev);
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, ev, mask, wd; logic err; int cyc;
        time t_prev, t_now;
        t_prev = 0;
        for (int k = 0; k < 8; k++) begin
            logic [9:0] a;
            a  = 10'(4 * (k % 4));
            wd = $urandom;
            if (k < 4) xfer(1'b0, 1'b1, a, wd, 4'hF, rd, err, cyc);
            else       xfer(1'b0, 1'b0, a, 32'h0, 4'h0, rd, err, cyc);
            t_now = $time;
            if (k < 4) begin
                model_wr(1'b0, a, wd, 4'hF);
            end else begin
                model_rd(1'b0, a, ev, mask);
                checks++;
                if (rd !== ev || err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_data k=%0d: prdata=%h pslverr=%b, want %h/0", k, rd, err, ev);
                end
            end
            checks++;
            if (cyc !== exp_cyc(1'b0) || (k > 0 && (t_now - t_prev) != 30)) begin
                errors++;
                $display("FAIL b2b_timing k=%0d: access=%0d period=%0t, want 2/30", k, cyc, t_now - t_prev);
            end
            t_prev = t_now;
        end
        bus_idle();
    endtask

    task automatic test_random();
        logic [31:0] rd, ev, mask, wd; logic err; int cyc;
        logic [9:0] a; logic [3:0] st; bit wr;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) < 7) a = 10'(4 * $urandom_range(0, 63));
            else                          a = 10'($urandom_range(0, 1023));
            wr = $urandom_range(0, 1) == 1;
            wd = $urandom;
            st = 4'($urandom_range(0, 15));
            xfer(1'b1, wr, a, wd, st, rd, err, cyc);
            checks++;
            if (wr) begin
                if (err !== exp_err(a) || cyc !== exp_cyc(1'b1)) begin
                    errors++;
                    $display("FAIL rand_write a=%h: pslverr=%b cycles=%0d, want %b/4", a, err, cyc, exp_err(a));
                end
                model_wr(1'b1, a, wd, st);
            end else begin
                model_rd(1'b1, a, ev, mask);
                if (err !== exp_err(a) || cyc !== exp_cyc(1'b1) || (rd & mask) !== (ev & mask)) begin
                    errors++;
                    $display("FAIL rand_read a=%h: prdata=%h pslverr=%b cycles=%0d, want %h mask %h/%b/4",
                             a, rd, err, cyc, ev, mask, exp_err(a));
                end
            end
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                mb[d][i] = 8'h00;
                mk[d][i] = 1'b0;
            end
        end
        test_reset();
        test_wait_states();
        test_strobes();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
